// File: rtl/id_stage_pkg.sv
// Shared decode vocabulary for the instruction-decode stage: ALU command codes,
// data-processing opcodes, instruction modes, condition codes and the condition test.
package id_stage_pkg;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  localparam logic [3:0] PC_INDEX = 4'd15;

  // status is packed N,Z,C,V from bit 3 down to bit 0
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    n = status[3];
    z = status[2];
    c = status[1];
    v = status[0];
    case (cond_e'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// Fifteen 32-bit general registers (R0..R14) with two combinational read ports,
// one clocked write port and write-through bypass; index 15 is never stored here.
module register_file
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [15];
  logic        bypass_ok;

  // A write presented while reset is held never lands, so it must not bypass either.
  assign bypass_ok = we && !rst && (waddr != PC_INDEX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (we && (waddr == 4'(i))) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 0; i < 15; i++) begin
      if (raddr1 == 4'(i)) rdata1 = regs[i];
      if (raddr2 == 4'(i)) rdata2 = regs[i];
    end
    if (bypass_ok && (waddr == raddr1)) rdata1 = wdata;
    if (bypass_ok && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field extraction, control decode, condition/hazard
// gating and register operand fetch with PC substituted for index 15.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] PC,
  input  logic [3:0]  status,
  input  logic        hazard,
  input  logic        WB_WB_EN,
  input  logic [3:0]  WB_Dest,
  input  logic [31:0] WB_Value,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        B,
  output logic        S,
  output logic        imm,
  output logic [3:0]  EXE_CMD,
  output logic [31:0] PC_out,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src
);

  logic [3:0]  cond, opcode, rn, rd;
  logic [1:0]  mode;
  logic        i_bit, s_bit;
  logic [11:0] shifter;
  logic        dec_wb, dec_mr, dec_mw, dec_b, dec_s, issue;
  exe_cmd_e    dec_cmd;
  logic [31:0] rf_rdata1, rf_rdata2;

  assign cond    = Instruction[31:28];
  assign mode    = Instruction[27:26];
  assign i_bit   = Instruction[25];
  assign opcode  = Instruction[24:21];
  assign s_bit   = Instruction[20];
  assign rn      = Instruction[19:16];
  assign rd      = Instruction[15:12];
  assign shifter = Instruction[11:0];

  always_comb begin
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_cmd = EXE_NOP;
    case (mode)
      MODE_DP: begin
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (opcode)
          OP_MOV: dec_cmd = EXE_MOV;
          OP_MVN: dec_cmd = EXE_MVN;
          OP_ADD: dec_cmd = EXE_ADD;
          OP_ADC: dec_cmd = EXE_ADC;
          OP_SUB: dec_cmd = EXE_SUB;
          OP_SBC: dec_cmd = EXE_SBC;
          OP_AND: dec_cmd = EXE_AND;
          OP_ORR: dec_cmd = EXE_ORR;
          OP_EOR: dec_cmd = EXE_EOR;
          // Compare/test only exist to set flags.
          OP_CMP: begin dec_cmd = EXE_SUB; dec_wb = 1'b0; dec_s = 1'b1; end
          OP_TST: begin dec_cmd = EXE_AND; dec_wb = 1'b0; dec_s = 1'b1; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        dec_cmd = EXE_ADD;
        if (s_bit) begin
          dec_mr = 1'b1;
          dec_wb = 1'b1;
        end else begin
          dec_mw = 1'b1;
        end
      end
      MODE_BR: dec_b = 1'b1;
      default: ;
    endcase
  end

  // Operand routing uses the ungated decode so hazard logic sees real sources.
  assign issue   = cond_pass(cond, status) && !hazard;
  assign src1    = rn;
  assign src2    = dec_mw ? rd : shifter[3:0];
  assign Two_src = ~i_bit | dec_mw;

  assign WB_EN    = issue & dec_wb;
  assign MEM_R_EN = issue & dec_mr;
  assign MEM_W_EN = issue & dec_mw;
  assign B        = issue & dec_b;
  assign S        = issue & dec_s;
  assign EXE_CMD  = issue ? dec_cmd : EXE_NOP;

  assign PC_out        = PC;
  assign imm           = i_bit;
  assign Shift_operand = shifter;
  assign Signed_imm_24 = Instruction[23:0];
  assign Dest          = rd;

  register_file u_register_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (WB_WB_EN),
    .waddr  (WB_Dest),
    .wdata  (WB_Value)
  );

  assign Val_Rn = (src1 == PC_INDEX) ? PC : rf_rdata1;
  assign Val_Rm = (src2 == PC_INDEX) ? PC : rf_rdata2;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The module SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 Inputs SHALL be: Instruction in 32, fetched word; PC in 32, PC+4 from IF register; status in 4, NZCV from status register; hazard in 1, freeze request; WB_WB_EN in 1, write-back enable; WB_Dest in 4, write-back register; WB_Value in 32, write-back data.
REQ-003 Outputs SHALL be: WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm (1 each); EXE_CMD 4; PC_out 32; Val_Rn 32; Val_Rm 32; Shift_operand 12; Signed_imm_24 24; Dest 4; src1 4; src2 4; Two_src 1.

Function
REQ-004 Fields SHALL decode as cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shifter[11:0], imm24[23:0].
REQ-005 For mode 00, opcode-to-EXE_CMD mapping SHALL be MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; other opcodes: all controls 0.
REQ-006 Mode 00 SHALL set WB_EN=1 except CMP/TST; S output = instruction S bit (CMP/TST force S=1).
REQ-007 Mode 01 SHALL give EXE_CMD=0010; S bit 1 -> LDR (MEM_R_EN=1, WB_EN=1); S bit 0 -> STR (MEM_W_EN=1, WB_EN=0).
REQ-008 Mode 10 SHALL give B=1, all other controls 0.
REQ-009 Condition check SHALL implement all 16 ARM codes (EQ..AL, 1111 = never) against status NZCV.
REQ-010 If condition fails or hazard=1, WB_EN, MEM_R_EN, MEM_W_EN, B, S SHALL be 0 and EXE_CMD 0000 in the same cycle; datapath outputs unaffected.
REQ-011 src1 SHALL equal Rn; src2 SHALL equal Rd when MEM_W_EN-decode=1, else shifter[3:0].
REQ-012 Two_src SHALL be (~I) OR store-decode, computed before condition/hazard gating.
REQ-013 Val_Rn/Val_Rm SHALL be combinational reads of src1/src2; index 15 SHALL return PC.
REQ-014 Register file SHALL hold R0..R14, 32 bits each, written on rising clk when WB_WB_EN=1 and WB_Dest!=15; WB_Dest=15 writes SHALL be ignored.
REQ-015 A read of the register being written in the same cycle SHALL return WB_Value (write-through bypass).
REQ-016 PC_out=PC, imm=I, Shift_operand=shifter, Signed_imm_24=imm24, Dest=Rd, combinationally, zero latency.
REQ-017 Only the register file SHALL be sequential; all decode outputs SHALL have zero-cycle latency.

Reset
REQ-018 rst=1 SHALL asynchronously clear R0..R14 to 0; reads during reset SHALL return 0 (index 15 returns PC).
REQ-019 Write-back asserted during reset SHALL be ignored; first write takes effect on the first rising edge with rst=0.
REQ-020 Reset SHALL not gate combinational decode outputs.

Structure
REQ-021 A shared package SHALL define EXE_CMD codes, data-processing opcodes, mode values and condition codes.
REQ-022 The register file SHALL be a sub-module register_file (clk, rst, two read ports, one write port, bypass inside).
REQ-023 Control decode and condition check SHALL be combinational logic within id_stage.

Verification
REQ-024 Reset, write R3=0x0000_00AA via write-back, then ADD R1,R3,R3 (0xE0831003) -> Val_Rn=Val_Rm=0xAA, EXE_CMD=0010, WB_EN=1, Dest=1, Two_src=1.
REQ-025 Same-cycle write R2=0x1234 with instruction reading R2 -> Val_Rn=0x1234 that cycle.
REQ-026 status Z=0, instruction MOVEQ R0,#5 (0x03A00005) -> all controls 0, imm=1, Shift_operand=0x005; with Z=1 -> EXE_CMD=0001, WB_EN=1.
REQ-027 STR R4,[R5] (0xE5854000) -> MEM_W_EN=1, WB_EN=0, src2=4, Two_src=1; LDR (0xE5954000) -> MEM_R_EN=1, WB_EN=1.
REQ-028 Branch 0xEA00_0010 with hazard=1 -> B=0; hazard=0 -> B=1, Signed_imm_24=0x000010.
REQ-029 Write R7=0xFFFF_FFFF, assert rst mid-cycle -> R7 reads 0 immediately; write to WB_Dest=15 -> no register changes.
